axi4_lite_manager_bridge: RTL and testbench
===========================================

Name: axi4_lite_manager_bridge

Overview:
- Converts the core's simple single-outstanding load/store request port into AXI4-Lite manager transactions.
- Sits directly upstream of the 4-port AXI4-Lite crossbar and drives its manager-side interface.
- Supports one transaction in flight, with independent AW/W handshakes and error reporting from BRESP/RRESP.
- Back-to-back requests are supported with no idle bubble beyond the response cycle.

Parameters:
- WIDTH, 32, data bus width; must be 32 or 64.
- ADDR_WIDTH, 32, address width.
- PROT, 3'b000, constant value driven on awprot/arprot.

Ports:
- aclk  input  1  clock; forwarded to axi.aclk.
- areset  input  1  asynchronous active-high reset; axi.areset_n = ~areset (combinational).
- req_valid  input  1  core request valid.
- req_ready  output  1  bridge can accept a request (high only in IDLE).
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  WIDTH  write data.
- req_wstrb  input  WIDTH/8  byte strobes (ignored on reads).
- rsp_done  output  1  one-cycle pulse: transaction complete.
- rsp_err  output  1  valid with rsp_done: response != OKAY.
- rsp_resp  output  2  raw BRESP/RRESP of the completed transaction.
- rsp_rdata  output  WIDTH  read data; held from done until the next read completes.
- axi  interface  -  axi4_lite.manager modport.

Behaviour:
- Clock and reset: one clock, aclk. Reset is asynchronous and active-high on areset.
- Reset values:
  - state = IDLE.
  - awvalid, wvalid, bready, arvalid, rready = 0.
  - rsp_done = 0, rsp_err = 0, rsp_resp = 0, rsp_rdata = 0.
  - Address/data/strobe holding registers = 0.
- States: IDLE, WR (AW+W phase), WR_RESP, RD_ADDR, RD_DATA.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch addr, wdata, wstrb. Go to WR if req_we, else RD_ADDR.
- WR:
  - awvalid and wvalid both asserted on entry; awaddr, wdata, wstrb come from the latched registers.
  - aw_done and w_done flags are set independently on their handshakes (valid & ready at the clock edge). Each valid drops the cycle after its own handshake.
  - Enter WR_RESP when both flags are set, including when both handshakes occur in the same cycle. Flags clear on exit.
- WR_RESP:
  - bready = 1.
  - On bvalid: capture bresp, go to IDLE, pulse rsp_done the next cycle.
- RD_ADDR:
  - arvalid = 1 with the latched address.
  - On arready: go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid: capture rdata and rresp, go to IDLE, pulse rsp_done the next cycle.
- Minimum latency (acceptance at edge N, zero-wait subordinate): AW/W/AR asserted in cycle N+1, response accepted in N+2, rsp_done in N+3.
- Back-to-back: in the rsp_done cycle the bridge is already in IDLE and req_ready = 1, so a new request is accepted that cycle.
- Valid stability: every AXI valid stays asserted, with stable payload, until its handshake. No valid is ever withdrawn.
- Errors:
  - rsp_err = (resp != OKAY). DECERR from the crossbar's unmapped-address path completes normally with rsp_err = 1.
  - On a read error, rsp_rdata still captures rdata (0 for DECERR).
- Core-side contract: req_* inputs are ignored outside IDLE, and the core must not rely on them being sampled later.
- Reset mid-transaction: all valids and readies drop immediately (asynchronously) and state returns to IDLE. No rsp_done is generated for the aborted transaction. The crossbar and subordinates are reset by the same areset_n.
- Outputs are registered except req_ready (decoded from state) and axi.areset_n.

Decomposition:
- axi4_lite_pkg holds:
  - the resp_t enum: OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11;
  - the bridge_state_t enum;
  - helper constant STRB_WIDTH = WIDTH/8.
- The crossbar's DECERR constant must reference the same enum.
- No sub-module; this is a single FSM plus holding registers.

Test Plan:
- Write 0x0000_0014 ← 0xDEADBEEF, strb 4'hF, zero-wait subordinate → AW/W in N+1, bready in N+2, rsp_done in N+3 with rsp_err = 0; the subordinate holds 0xDEADBEEF.
- Write with AW ready 3 cycles later than W → wvalid drops after its handshake, awvalid holds 3 more cycles, WR_RESP entered only after both; single rsp_done.
- Read 0x0000_0024 with 2-cycle arready and 4-cycle rvalid delays, rdata 0x1234_5678 → rsp_rdata = 0x1234_5678, rsp_resp = OKAY, rsp_done exactly once.
- Read 0x0000_0040 (unmapped) through the crossbar → rsp_err = 1, rsp_resp = DECERR, rsp_rdata = 0.
- Back-to-back write then read to 0x10 with req_valid held → second request accepted in the first transaction's rsp_done cycle; no dropped or duplicate transaction.
- Assert areset in the middle of WR_RESP → awvalid, wvalid, bready, arvalid, rready = 0 in the same cycle; no rsp_done; req_ready = 1 after release.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes, bridge FSM states and strobe-width helper.
// The crossbar's DECERR path uses the same resp_t encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } bridge_state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned STRB_WIDTH    = DEFAULT_WIDTH / 8;

    function automatic int unsigned strb_width(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle with manager/subordinate views; clock and reset travel with the bus.
interface axi4_lite #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 32
) ();
    import axi4_lite_pkg::*;

    logic                           aclk;
    logic                           areset_n;

    logic                           awvalid;
    logic                           awready;
    logic [ADDR_WIDTH-1:0]          awaddr;
    logic [2:0]                     awprot;

    logic                           wvalid;
    logic                           wready;
    logic [WIDTH-1:0]               wdata;
    logic [strb_width(WIDTH)-1:0]   wstrb;

    logic                           bvalid;
    logic                           bready;
    resp_t                          bresp;

    logic                           arvalid;
    logic                           arready;
    logic [ADDR_WIDTH-1:0]          araddr;
    logic [2:0]                     arprot;

    logic                           rvalid;
    logic                           rready;
    logic [WIDTH-1:0]               rdata;
    resp_t                          rresp;

    modport manager (
        output aclk, areset_n,
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp, output rready
    );

    modport subordinate (
        input  aclk, areset_n,
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );

endinterface

// File: rtl/axi4_lite_manager_bridge.sv
// Single-outstanding core load/store port to AXI4-Lite manager bridge.
// One FSM with registered valids/readies and response outputs; req_ready decoded from state.
module axi4_lite_manager_bridge
    import axi4_lite_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [WIDTH-1:0]             req_wdata,
    input  logic [strb_width(WIDTH)-1:0] req_wstrb,
    output logic                         rsp_done,
    output logic                         rsp_err,
    output logic [1:0]                   rsp_resp,
    output logic [WIDTH-1:0]             rsp_rdata,
    axi4_lite.manager                    axi
);

    if (WIDTH != 32 && WIDTH != 64) begin : g_width_check
        $error("axi4_lite_manager_bridge: WIDTH must be 32 or 64");
    end

    bridge_state_t                  state;
    logic [ADDR_WIDTH-1:0]          addr_q;
    logic [WIDTH-1:0]               wdata_q;
    logic [strb_width(WIDTH)-1:0]   wstrb_q;
    logic                           awvalid_q;
    logic                           wvalid_q;
    logic                           bready_q;
    logic                           arvalid_q;
    logic                           rready_q;
    logic                           aw_done;
    logic                           w_done;
    logic                           aw_fire;
    logic                           w_fire;

    assign axi.aclk     = aclk;
    assign axi.areset_n = ~areset;

    assign axi.awvalid  = awvalid_q;
    assign axi.awaddr   = addr_q;
    assign axi.awprot   = PROT;
    assign axi.wvalid   = wvalid_q;
    assign axi.wdata    = wdata_q;
    assign axi.wstrb    = wstrb_q;
    assign axi.bready   = bready_q;
    assign axi.arvalid  = arvalid_q;
    assign axi.araddr   = addr_q;
    assign axi.arprot   = PROT;
    assign axi.rready   = rready_q;

    assign req_ready    = (state == IDLE);

    assign aw_fire      = awvalid_q & axi.awready;
    assign w_fire       = wvalid_q & axi.wready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_done  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_resp  <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wstrb_q <= req_wstrb;
                        if (req_we) begin
                            state     <= WR;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state     <= RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end

                // AW and W complete independently; the exit test also counts
                // handshakes landing on this very edge.
                WR: begin
                    if (aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        state    <= WR_RESP;
                        bready_q <= 1'b1;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                    end
                end

                WR_RESP: begin
                    if (axi.bvalid) begin
                        state    <= IDLE;
                        bready_q <= 1'b0;
                        rsp_done <= 1'b1;
                        rsp_err  <= (axi.bresp != OKAY);
                        rsp_resp <= axi.bresp;
                    end
                end

                RD_ADDR: begin
                    if (axi.arready) begin
                        state     <= RD_DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end

                RD_DATA: begin
                    if (axi.rvalid) begin
                        state     <= IDLE;
                        rready_q  <= 1'b0;
                        rsp_done  <= 1'b1;
                        rsp_err   <= (axi.rresp != OKAY);
                        rsp_resp  <= axi.rresp;
                        rsp_rdata <= axi.rdata;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_manager_bridge.sv
// Bench for axi4_lite_manager_bridge: delay-programmable subordinate with a small address map,
// reference model feeding an expected-response queue, and an independent response monitor.
module tb_axi4_lite_manager_bridge;
    import axi4_lite_pkg::*;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_done;
    logic        rsp_err;
    logic [1:0]  rsp_resp;
    logic [31:0] rsp_rdata;

    axi4_lite #(.WIDTH(32), .ADDR_WIDTH(32)) axi ();

    axi4_lite_manager_bridge #(.WIDTH(32), .ADDR_WIDTH(32), .PROT(3'b000)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_done  (rsp_done),
        .rsp_err   (rsp_err),
        .rsp_resp  (rsp_resp),
        .rsp_rdata (rsp_rdata),
        .axi       (axi)
    );

    int checks = 0;
    int errors = 0;
    int issued = 0;
    int aborted = 0;
    int done_count = 0;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] last_rd;
    logic [31:0] sub_mem [16];

    // Per-channel subordinate delays in cycles; negative means random 0..3.
    int aw_dly_cfg = 0, w_dly_cfg = 0, b_dly_cfg = 0, ar_dly_cfg = 0, r_dly_cfg = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int pick(input int cfg);
        return (cfg < 0) ? int'($urandom_range(0, 3)) : cfg;
    endfunction

    // Address map: 0x00-0x37 RAM, 0x38-0x3F read-only (writes SLVERR), >= 0x40 unmapped (DECERR).
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output exp_t e);
        logic [31:0] rd;
        rd     = 32'h0;
        e.we   = we;
        e.addr = addr;
        if (addr >= 32'h40) begin
            e.resp = DECERR;
        end else if (we && addr >= 32'h38) begin
            e.resp = SLVERR;
        end else begin
            e.resp = OKAY;
            if (we) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = data[8*b +: 8];
            end else begin
                rd = ref_mem[addr[5:2]];
            end
        end
        if (!we) last_rd = rd;
        e.rdata = last_rd;
    endtask

    // ---------------- subordinate ----------------
    bit          aw_arm, w_arm, b_arm, ar_arm, r_arm;
    bit          got_aw, got_w, got_ar;
    bit          aw_f, w_f, b_f, ar_f, r_f;
    int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    resp_t       s_bresp, s_rresp;
    logic [31:0] s_rdata;

    task automatic sub_clear();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        axi.arready = 1'b0; axi.rvalid = 1'b0;
        axi.bresp = OKAY; axi.rresp = OKAY; axi.rdata = '0;
        aw_arm = 0; w_arm = 0; b_arm = 0; ar_arm = 0; r_arm = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
        aw_f = 0; w_f = 0; b_f = 0; ar_f = 0; r_f = 0;
    endtask

    initial begin : subordinate
        for (int i = 0; i < 16; i++) sub_mem[i] = '0;
        sub_clear();
        forever begin
            @(negedge aclk);
            if (!axi.areset_n) begin
                sub_clear();
                continue;
            end
            if (aw_f) begin got_aw = 1; aw_arm = 0; axi.awready = 1'b0; end
            if (w_f)  begin got_w = 1;  w_arm = 0;  axi.wready = 1'b0; end
            if (b_f)  begin axi.bvalid = 1'b0; got_aw = 0; got_w = 0; b_arm = 0; end
            if (ar_f) begin got_ar = 1; ar_arm = 0; axi.arready = 1'b0; end
            if (r_f)  begin axi.rvalid = 1'b0; got_ar = 0; r_arm = 0; end

            if (axi.awvalid && !got_aw && !axi.awready) begin
                if (!aw_arm) begin aw_arm = 1; aw_cnt = pick(aw_dly_cfg); end
                if (aw_cnt == 0) begin axi.awready = 1'b1; s_awaddr = axi.awaddr; end
                else aw_cnt--;
            end
            if (axi.wvalid && !got_w && !axi.wready) begin
                if (!w_arm) begin w_arm = 1; w_cnt = pick(w_dly_cfg); end
                if (w_cnt == 0) begin axi.wready = 1'b1; s_wdata = axi.wdata; s_wstrb = axi.wstrb; end
                else w_cnt--;
            end
            if (got_aw && got_w && !b_arm) begin
                b_arm = 1;
                b_cnt = pick(b_dly_cfg);
                if (s_awaddr >= 32'h40) s_bresp = DECERR;
                else if (s_awaddr >= 32'h38) s_bresp = SLVERR;
                else begin
                    s_bresp = OKAY;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) sub_mem[s_awaddr[5:2]][8*b +: 8] = s_wdata[8*b +: 8];
                end
            end
            if (b_arm && !axi.bvalid) begin
                if (b_cnt == 0) begin axi.bvalid = 1'b1; axi.bresp = s_bresp; end
                else b_cnt--;
            end
            if (axi.arvalid && !got_ar && !axi.arready) begin
                if (!ar_arm) begin ar_arm = 1; ar_cnt = pick(ar_dly_cfg); end
                if (ar_cnt == 0) begin axi.arready = 1'b1; s_araddr = axi.araddr; end
                else ar_cnt--;
            end
            if (got_ar && !r_arm) begin
                r_arm = 1;
                r_cnt = pick(r_dly_cfg);
                if (s_araddr >= 32'h40) begin s_rresp = DECERR; s_rdata = '0; end
                else begin s_rresp = OKAY; s_rdata = sub_mem[s_araddr[5:2]]; end
            end
            if (r_arm && !axi.rvalid) begin
                if (r_cnt == 0) begin axi.rvalid = 1'b1; axi.rresp = s_rresp; axi.rdata = s_rdata; end
                else r_cnt--;
            end

            aw_f = axi.awvalid && axi.awready;
            w_f  = axi.wvalid && axi.wready;
            b_f  = axi.bvalid && axi.bready;
            ar_f = axi.arvalid && axi.arready;
            r_f  = axi.rvalid && axi.rready;
        end
    end

    // ---------------- response monitor ----------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge aclk);
            #1;
            if (rsp_done) begin
                done_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp_done: got resp %0h with no transaction outstanding", rsp_resp);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                    check("rsp_err", 64'(rsp_err), 64'(e.resp != 2'b00));
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                end
            end
        end
    end

    // ---------------- valid stability monitor ----------------
    bit          aw_p, w_p, ar_p;
    logic [31:0] aw_a, w_d, ar_a;
    logic [3:0]  w_s;

    initial begin : stability
        aw_p = 0; w_p = 0; ar_p = 0;
        forever begin
            @(negedge aclk);
            #1;
            if (areset) begin
                aw_p = 0; w_p = 0; ar_p = 0;
                continue;
            end
            if (aw_p) check("awvalid_stable", {31'h0, axi.awvalid, axi.awaddr}, {31'h0, 1'b1, aw_a});
            if (w_p)  check("wvalid_stable", {27'h0, axi.wvalid, axi.wstrb, axi.wdata}, {27'h0, 1'b1, w_s, w_d});
            if (ar_p) check("arvalid_stable", {31'h0, axi.arvalid, axi.araddr}, {31'h0, 1'b1, ar_a});
            aw_p = axi.awvalid && !axi.awready; aw_a = axi.awaddr;
            w_p  = axi.wvalid && !axi.wready;   w_d  = axi.wdata; w_s = axi.wstrb;
            ar_p = axi.arvalid && !axi.arready; ar_a = axi.araddr;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, output bit done_at_accept);
        exp_t e;
        model(we, addr, data, strb, e);
        exp_q.push_back(e);
        issued++;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wstrb = strb;
        done_at_accept = 0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                done_at_accept = rsp_done;
                @(negedge aclk);
                return;
            end
            @(negedge aclk);
        end
        checks++;
        errors++;
        $display("FAIL issue_timeout: req_ready %0b, required 1 within 300 cycles", req_ready);
    endtask

    task automatic drop_req();
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && req_ready) return;
            @(negedge aclk);
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout: %0d responses outstanding, required 0", exp_q.size());
    endtask

    task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
        aw_dly_cfg = aw; w_dly_cfg = w; b_dly_cfg = b; ar_dly_cfg = ar; r_dly_cfg = r;
    endtask

    // ---------------- main sequence ----------------
    initial begin : driver
        bit d;
        areset    = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        last_rd   = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        repeat (3) @(negedge aclk);
        check("reset_valids", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
        check("reset_rsp", {rsp_done, rsp_err, rsp_resp, rsp_rdata}, 36'h0);
        check("reset_areset_n", 64'(axi.areset_n), 64'h0);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("post_reset_req_ready", 64'(req_ready), 64'h1);
        check("post_reset_areset_n", 64'(axi.areset_n), 64'h1);

        // Zero-wait write: AW/W in N+1, bready in N+2, rsp_done in N+3.
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 32'h14, 32'hDEADBEEF, 4'hF, d);
        drop_req();
        check("t1_aw_w_n1", {axi.awvalid, axi.wvalid, axi.bready}, 3'b110);
        check("t1_awaddr", 64'(axi.awaddr), 64'h14);
        @(negedge aclk);
        check("t1_bready_n2", {axi.awvalid, axi.wvalid, axi.bready, rsp_done}, 4'b0010);
        @(negedge aclk);
        check("t1_done_n3", {rsp_done, rsp_err, req_ready}, 3'b101);
        wait_idle();
        check("t1_sub_mem", 64'(sub_mem[5]), 64'hDEADBEEF);

        // AW ready three cycles after W.
        set_dly(3, 0, 0, 0, 0);
        issue(1'b1, 32'h20, 32'hA5A5_0F0F, 4'hF, d);
        drop_req();
        check("t2_valids_n1", {axi.awvalid, axi.wvalid}, 2'b11);
        for (int k = 2; k <= 4; k++) begin
            @(negedge aclk);
            check("t2_aw_hold", {axi.awvalid, axi.wvalid, axi.bready}, 3'b100);
        end
        @(negedge aclk);
        check("t2_wr_resp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        wait_idle();

        // Read with slow AR and R.
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 32'h24, 32'h1234_5678, 4'hF, d);
        drop_req();
        wait_idle();
        set_dly(0, 0, 0, 2, 4);
        issue(1'b0, 32'h24, 32'h0, 4'h0, d);
        drop_req();
        repeat (2) @(negedge aclk);
        check("t3_arvalid_hold", {axi.arvalid, axi.rready}, 2'b10);
        @(negedge aclk);
        check("t3_rready", {axi.arvalid, axi.rready}, 2'b01);
        wait_idle();

        // Unmapped read: DECERR with zero data.
        set_dly(0, 0, 0, 1, 1);
        issue(1'b0, 32'h40, 32'h0, 4'h0, d);
        drop_req();
        wait_idle();

        // Back-to-back write then read with req_valid held.
        set_dly(0, 0, 0, 0, 0);
        issue(1'b1, 32'h10, 32'hCAFE_F00D, 4'hF, d);
        issue(1'b0, 32'h10, 32'h0, 4'h0, d);
        check("t5_accept_in_done_cycle", 64'(d), 64'h1);
        drop_req();
        wait_idle();

        // Reset while waiting for BRESP.
        set_dly(0, 0, 10, 0, 0);
        issue(1'b1, 32'h08, 32'h0BAD_0BAD, 4'hF, d);
        drop_req();
        for (int i = 0; i < 20 && !axi.bready; i++) @(negedge aclk);
        check("t6_in_wr_resp", 64'(axi.bready), 64'h1);
        #2 areset = 1'b1;
        void'(exp_q.pop_back());
        aborted++;
        #1;
        check("t6_async_drop", {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}, 5'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge aclk);
            check("t6_no_done", 64'(rsp_done), 64'h0);
        end
        #2 areset = 1'b0;
        last_rd = '0;
        @(negedge aclk);
        check("t6_req_ready_after", {req_ready, rsp_done}, 2'b10);

        // Randomized traffic with random channel delays.
        set_dly(-1, -1, -1, -1, -1);
        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 1)), 32'($urandom_range(0, 19)) * 4, $urandom,
                  4'($urandom_range(0, 15)), d);
            if ($urandom_range(0, 2) == 0) begin
                drop_req();
                repeat ($urandom_range(0, 3)) @(negedge aclk);
            end
        end
        drop_req();
        wait_idle();
        repeat (3) @(negedge aclk);

        for (int i = 0; i < 16; i++) check("final_mem", 64'(sub_mem[i]), 64'(ref_mem[i]));
        check("done_count", 64'(done_count), 64'(issued - aborted));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
